// File: rtl/register_file_scoreboard.sv
// Multi-port integer register file with post-reset zero sequencer and busy scoreboard.
// Optional same-cycle write-to-read forwarding via REGFILE_WRITE_BYPASS_EN.
module register_file_scoreboard #(
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_REGISTERS  = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int NUM_READ_PORTS = 3,
  parameter int ZERO_REG       = 1
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 in_write_enable,
  input  logic [ADDR_WIDTH-1:0]                in_write_register_select,
  input  logic [DATA_WIDTH-1:0]                in_write_data,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH-1:0] in_read_register_select,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0] out_read_data,
  input  logic                                 in_reserve_enable,
  input  logic [ADDR_WIDTH-1:0]                in_reserve_register_select,
  output logic [NUM_REGISTERS-1:0]             out_busy,
  output logic                                 out_ready
);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   counter, counter_next;
  logic [NUM_REGISTERS-1:0] busy_next;
  logic [DATA_WIDTH-1:0]   mem [NUM_REGISTERS];
  logic                    run;
  logic                    wr_ok;
  logic                    last;

  assign run   = (state == S_RUN);
  assign last  = (counter == ADDR_WIDTH'(NUM_REGISTERS - 1));
  assign wr_ok = in_write_enable &&
                 !(ZERO_REG != 0 && in_write_register_select == '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_INIT;
      counter <= '0;
    end else begin
      state   <= state_next;
      counter <= counter_next;
    end
  end

  always_comb begin
    state_next   = state;
    counter_next = counter;
    unique case (1'b1)
      (state == S_INIT): begin
        counter_next = counter + 1'b1;
        if (last) state_next = S_RUN;
      end
      (state == S_RUN): begin
        counter_next = counter;
      end
    endcase
  end

  assign out_ready = run;

  // Storage is not reset; the sequencer clears it instead.
  always_ff @(posedge clk) begin
    if (!run) begin
      mem[counter] <= '0;
    end else if (wr_ok) begin
      mem[in_write_register_select] <= in_write_data;
    end
  end

  always_comb begin
    out_read_data = '0;
    for (int k = 0; k < NUM_READ_PORTS; k++) begin
      logic [ADDR_WIDTH-1:0] sel;
      sel = in_read_register_select[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (!run) begin
        out_read_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      end else if (ZERO_REG != 0 && sel == '0) begin
        out_read_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
`ifdef REGFILE_WRITE_BYPASS_EN
      end else if (in_write_enable &&
                   sel == in_write_register_select) begin
        out_read_data[k*DATA_WIDTH +: DATA_WIDTH] = in_write_data;
`endif
      end else begin
        out_read_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[sel];
      end
    end
  end

  // A reserve after the clear means a new producer wins the race.
  always_comb begin
    busy_next = out_busy;
    if (run) begin
      if (in_write_enable)
        busy_next[in_write_register_select] = 1'b0;
      if (in_reserve_enable)
        busy_next[in_reserve_register_select] = 1'b1;
    end else begin
      busy_next = '0;
    end
    if (ZERO_REG != 0) busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_busy <= '0;
    end else begin
      out_busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
// Bench for register_file_scoreboard: directed steps plus random traffic
// against an array-based reference model; also a small second configuration.
module tb_register_file_scoreboard;

  localparam int DW = 64;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NP = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic             we;
  logic [AW-1:0]    wsel;
  logic [DW-1:0]    wdata;
  logic [NP*AW-1:0] rsel;
  logic [NP*DW-1:0] rdata;
  logic             res_en;
  logic [AW-1:0]    res_sel;
  logic [NR-1:0]    busy;
  logic             ready;

  logic          b_we;
  logic [3:0]    b_wsel;
  logic [31:0]   b_wdata;
  logic [7:0]    b_rsel;
  logic [63:0]   b_rdata;
  logic          b_res;
  logic [3:0]    b_res_sel;
  logic [15:0]   b_busy;
  logic          b_ready;

  register_file_scoreboard dut (
    .clk                        (clk),
    .reset                      (reset),
    .in_write_enable            (we),
    .in_write_register_select   (wsel),
    .in_write_data              (wdata),
    .in_read_register_select    (rsel),
    .out_read_data              (rdata),
    .in_reserve_enable          (res_en),
    .in_reserve_register_select (res_sel),
    .out_busy                   (busy),
    .out_ready                  (ready)
  );

  register_file_scoreboard #(
    .DATA_WIDTH     (32),
    .NUM_REGISTERS  (16),
    .ADDR_WIDTH     (4),
    .NUM_READ_PORTS (2),
    .ZERO_REG       (0)
  ) dut2 (
    .clk                        (clk),
    .reset                      (reset),
    .in_write_enable            (b_we),
    .in_write_register_select   (b_wsel),
    .in_write_data              (b_wdata),
    .in_read_register_select    (b_rsel),
    .out_read_data              (b_rdata),
    .in_reserve_enable          (b_res),
    .in_reserve_register_select (b_res_sel),
    .out_busy                   (b_busy),
    .out_ready                  (b_ready)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_reg [NR];
  bit            m_busy [NR];
  int            m_cyc;

  task automatic chk(input string tag, input logic [191:0] obs,
                     input logic [191:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_read(input int s);
    if (m_cyc < NR) return '0;
    if (s == 0) return '0;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we && int'(wsel) == s) return wdata;
`endif
    return m_reg[s];
  endfunction

  function automatic logic [NR-1:0] exp_busy();
    logic [NR-1:0] v;
    v = '0;
    if (m_cyc >= NR)
      for (int i = 0; i < NR; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic model_reset();
    m_cyc = 0;
    for (int i = 0; i < NR; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < NP; k++)
      chk($sformatf("read_p%0d_r%0d", k, rsel[k*AW +: AW]),
          192'(rdata[k*DW +: DW]),
          192'(exp_read(int'(rsel[k*AW +: AW]))));
    chk("busy", 192'(busy), 192'(exp_busy()));
    chk("ready", 192'(ready), 192'(m_cyc >= NR));
    chk("b_ready", 192'(b_ready), 192'(m_cyc >= 16));
  endtask

  task automatic step();
    @(negedge clk);
    check_all();
    @(posedge clk);
    if (!reset) begin
      model_reset();
    end else if (m_cyc < NR) begin
      m_cyc++;
    end else begin
      if (we && wsel != 0) m_reg[wsel] = wdata;
      if (we) m_busy[wsel] = 1'b0;
      if (res_en && res_sel != 0) m_busy[res_sel] = 1'b1;
    end
    #1;
  endtask

  task automatic idle();
    we = 1'b0;
    res_en = 1'b0;
  endtask

  task automatic all_sel(input logic [AW-1:0] s);
    rsel = {s, s, s};
  endtask

  initial begin
    reset = 1'b0;
    we = 1'b0; wsel = '0; wdata = '0; rsel = '0;
    res_en = 1'b0; res_sel = '0;
    b_we = 1'b0; b_wsel = '0; b_wdata = '0; b_rsel = '0;
    b_res = 1'b0; b_res_sel = '0;
    model_reset();

    repeat (3) step();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    m_cyc = 1;

    // Init phase: inputs ignored, reads zero, ready low for exactly NR cycles.
    for (int i = 0; i < NR + 2; i++) begin
      we = 1'b1;
      wsel = AW'($urandom);
      wdata = {$urandom, $urandom};
      res_en = 1'b1;
      res_sel = AW'($urandom);
      rsel = NP*AW'($urandom);
      step();
      if (m_cyc >= NR) break;
    end
    idle();

    b_we = 1'b1; b_wsel = 4'd0; b_wdata = 32'h7;
    step();
    b_we = 1'b0;
    b_rsel = {4'd1, 4'd0};
    #1;
    chk("b_read_r0", 192'(b_rdata[31:0]), 192'(32'h7));
    chk("b_read_r1", 192'(b_rdata[63:32]), 192'(32'h0));
    b_res = 1'b1; b_res_sel = 4'd0;
    step();
    b_res = 1'b0;
    chk("b_busy0", 192'(b_busy), 192'(16'h0001));

    we = 1'b1; wsel = 5'd5; wdata = 64'hDEAD_BEEF_0000_0001;
    step();
    idle();
    all_sel(5'd5);
    step();
    we = 1'b1; wsel = 5'd0; wdata = 64'h55;
    step();
    idle();
    all_sel(5'd0);
    step();

    res_en = 1'b1; res_sel = 5'd7;
    step();
    idle();
    step();
    we = 1'b1; wsel = 5'd7; wdata = 64'h1234;
    step();
    idle();
    all_sel(5'd7);
    step();
    we = 1'b1; wsel = 5'd9; wdata = 64'h99;
    res_en = 1'b1; res_sel = 5'd9;
    step();
    idle();
    res_en = 1'b1; res_sel = 5'd0;
    step();
    idle();
    step();

    rsel = {5'd0, 5'd3, 5'd0};
    we = 1'b1; wsel = 5'd3; wdata = 64'hAA;
    step();
    idle();
    step();

    for (int i = 0; i < 400; i++) begin
      we = 1'($urandom);
      wsel = AW'($urandom);
      wdata = {$urandom, $urandom};
      res_en = 1'($urandom);
      res_sel = ($urandom_range(0, 3) == 0) ? wsel : AW'($urandom);
      for (int k = 0; k < NP; k++)
        rsel[k*AW +: AW] = ($urandom_range(0, 2) == 0) ? wsel : AW'($urandom);
      step();
    end
    idle();

    we = 1'b1; wsel = 5'd10; wdata = 64'hFF;
    res_en = 1'b1; res_sel = 5'd11;
    step();
    idle();
    all_sel(5'd10);
    step();
    #2;
    reset = 1'b0;
    #1;
    chk("ready_async_drop", 192'(ready), 192'(1'b0));
    chk("busy_async_drop", 192'(busy), 192'(32'h0));
    model_reset();
    step();
    step();
    reset = 1'b1;
    for (int i = 0; i < NR + 4; i++) begin
      all_sel(5'd10);
      step();
    end
    rsel = {5'd11, 5'd10, 5'd10};
    step();
    chk("busy11_after_reinit", 192'(busy[11]), 192'(1'b0));
    chk("r10_after_reinit", 192'(rdata[DW-1:0]), 192'(64'h0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
